// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared widths, slot codes and reader state encoding
// for the calculator result path.
package calc_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 2;

   localparam logic [ADDR_W-1:0] SLOT_ADD  = 2'd0;
   localparam logic [ADDR_W-1:0] SLOT_MULT = 2'd1;
   localparam logic [ADDR_W-1:0] SLOT_SUB  = 2'd2;
   localparam logic [ADDR_W-1:0] SLOT_DIV  = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      SEEK,
      WAIT,
      CAPTURE,
      HOLD
   } reader_state_t;

endpackage

// File: rtl/calc_slot_seek.sv
// rtl/calc_slot_seek.sv - rotating priority pick of the next written slot
// after ptr, falling back to ptr itself when it is the only one.
module calc_slot_seek #(
   parameter int ADDR_W = calc_pkg::ADDR_W
) (
   input  logic [ADDR_W-1:0]        ptr,
   input  logic [(1<<ADDR_W)-1:0]   slot_valid,
   output logic [ADDR_W-1:0]        next_slot,
   output logic                     any_valid
);

   localparam int NSLOT = 1 << ADDR_W;

   // Scan farthest-first so the nearest valid slot (ptr+1) overwrites last.
   always_comb begin
      next_slot = ptr;
      for (int k = NSLOT; k >= 1; k--) begin
         if (slot_valid[ptr + ADDR_W'(k)]) begin
            next_slot = ptr + ADDR_W'(k);
         end
      end
      any_valid = |slot_valid;
   end

endmodule

// File: rtl/calc_result_reader.sv
// rtl/calc_result_reader.sv - snoops result writes, reads valid slots back
// through the registered memory port and presents one at a time to the display.
module calc_result_reader #(
   parameter int DATA_W       = calc_pkg::DATA_W,
   parameter int ADDR_W       = calc_pkg::ADDR_W,
   parameter int DWELL_CYCLES = 100_000_000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic                     clr,
   input  logic                     step,
   input  logic                     auto_en,
   output logic [ADDR_W-1:0]        rd_addr,
   input  logic [DATA_W-1:0]        rd_data,
   output logic [DATA_W-1:0]        disp_data,
   output logic [ADDR_W-1:0]        disp_addr,
   output logic                     disp_valid,
   output logic [(1<<ADDR_W)-1:0]   slot_valid
);

   import calc_pkg::*;

   localparam int NSLOT = 1 << ADDR_W;
   localparam int DW_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
   localparam logic [ADDR_W-1:0] PTR_RST    = '1;

   // Assertion is immediate; release is delayed two edges to stay glitch-free.
   logic [1:0] rst_sync_q;
   logic       rst_ni;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= '0;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_ni = rst_sync_q[1];

   reader_state_t     state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0] disp_data_q, disp_data_d;
   logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
   logic              disp_valid_q, disp_valid_d;
   logic [NSLOT-1:0]  slot_valid_q, slot_valid_d;
   logic [DW_W-1:0]   dwell_q, dwell_d;
   logic [ADDR_W-1:0] next_slot;
   logic              any_valid;
   logic              refresh;
   logic              advance;

   calc_slot_seek #(.ADDR_W(ADDR_W)) u_seek (
      .ptr        (ptr_q),
      .slot_valid (slot_valid_q),
      .next_slot  (next_slot),
      .any_valid  (any_valid)
   );

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      rd_addr_d    = rd_addr_q;
      disp_data_d  = disp_data_q;
      disp_addr_d  = disp_addr_q;
      disp_valid_d = disp_valid_q;
      slot_valid_d = slot_valid_q;
      dwell_d      = '0;
      refresh      = wr_en && (wr_addr == rd_addr_q);
      advance      = step || (auto_en && (dwell_q == DWELL_LAST));

      if (wr_en) slot_valid_d[wr_addr] = 1'b1;

      case (state_q)
         IDLE: begin
            if (|slot_valid_q) state_d = SEEK;
         end
         SEEK: begin
            if (any_valid) begin
               rd_addr_d = next_slot;
               ptr_d     = next_slot;
               state_d   = WAIT;
            end else begin
               state_d   = IDLE;
            end
         end
         WAIT: begin
            state_d = refresh ? WAIT : CAPTURE;
         end
         CAPTURE: begin
            disp_data_d  = rd_data;
            disp_addr_d  = rd_addr_q;
            disp_valid_d = 1'b1;
            state_d      = refresh ? WAIT : HOLD;
         end
         HOLD: begin
            if (advance)      state_d = SEEK;
            else if (refresh) state_d = WAIT;
            if (auto_en && !advance) dwell_d = dwell_q + DW_W'(1);
         end
         default: state_d = IDLE;
      endcase

      // Clear overrides everything, including a same-cycle write.
      if (clr) begin
         slot_valid_d = '0;
         state_d      = IDLE;
         disp_valid_d = 1'b0;
         ptr_d        = PTR_RST;
         dwell_d      = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         ptr_q        <= PTR_RST;
         rd_addr_q    <= '0;
         disp_data_q  <= '0;
         disp_addr_q  <= '0;
         disp_valid_q <= 1'b0;
         slot_valid_q <= '0;
         dwell_q      <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         rd_addr_q    <= rd_addr_d;
         disp_data_q  <= disp_data_d;
         disp_addr_q  <= disp_addr_d;
         disp_valid_q <= disp_valid_d;
         slot_valid_q <= slot_valid_d;
         dwell_q      <= dwell_d;
      end
   end

   assign rd_addr    = rd_addr_q;
   assign disp_data  = disp_data_q;
   assign disp_addr  = disp_addr_q;
   assign disp_valid = disp_valid_q;
   assign slot_valid = slot_valid_q;

endmodule

// File: tb/tb_calc_result_reader.sv
// tb/tb_calc_result_reader.sv - directed bench for calc_result_reader with
// a registered-read memory model.
module tb_calc_result_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_addr = 2'd0;
   logic [15:0] wr_data = 16'h0;
   logic        clr = 1'b0;
   logic        step = 1'b0;
   logic        auto_en = 1'b0;
   logic [1:0]  rd_addr;
   logic [15:0] rd_data;
   logic [15:0] disp_data;
   logic [1:0]  disp_addr;
   logic        disp_valid;
   logic [3:0]  slot_valid;
   logic [15:0] mem [4];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

   calc_result_reader #(.DATA_W(16), .ADDR_W(2), .DWELL_CYCLES(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .clr        (clr),
      .step       (step),
      .auto_en    (auto_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .disp_data  (disp_data),
      .disp_addr  (disp_addr),
      .disp_valid (disp_valid),
      .slot_valid (slot_valid)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_write(input logic [1:0] a, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic pulse_step;
      step = 1'b1; tick(1); step = 1'b0;
   endtask

   task automatic pulse_clr;
      clr = 1'b1; tick(1); clr = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick(2);
      total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL reset_disp_valid got=%0b want=0", disp_valid); end
      total++; if (slot_valid !== 4'b0000) begin bad++; $display("FAIL reset_slot_valid got=%b want=0000", slot_valid); end
      total++; if (rd_addr !== 2'd0) begin bad++; $display("FAIL reset_rd_addr got=%0d want=0", rd_addr); end
      total++; if (disp_addr !== 2'd0) begin bad++; $display("FAIL reset_disp_addr got=%0d want=0", disp_addr); end
      total++; if (disp_data !== 16'h0000) begin bad++; $display("FAIL reset_disp_data got=%h want=0000", disp_data); end
      rst_n = 1'b1;
      tick(3);
      total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL post_reset_disp_valid got=%0b want=0", disp_valid); end
   endtask

   task automatic test_first_write;
      do_write(2'd1, 16'h0078);
      total++; if (slot_valid !== 4'b0010) begin bad++; $display("FAIL first_slot_valid got=%b want=0010", slot_valid); end
      tick(3);
      total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL first_early_valid got=%0b want=0", disp_valid); end
      tick(1);
      total++; if (disp_valid !== 1'b1) begin bad++; $display("FAIL first_disp_valid got=%0b want=1", disp_valid); end
      total++; if (disp_addr !== 2'd1) begin bad++; $display("FAIL first_disp_addr got=%0d want=1", disp_addr); end
      total++; if (disp_data !== 16'h0078) begin bad++; $display("FAIL first_disp_data got=%h want=0078", disp_data); end
      total++; if (rd_addr !== 2'd1) begin bad++; $display("FAIL first_rd_addr got=%0d want=1", rd_addr); end
   endtask

   task automatic test_step;
      logic [1:0]  exp_a [3] = '{2'd2, 2'd3, 2'd0};
      logic [15:0] exp_d [3] = '{16'hFFFD, 16'h0002, 16'h0005};
      logic [1:0]  prev_a;
      pulse_clr;
      total++; if (slot_valid !== 4'b0000) begin bad++; $display("FAIL step_clr_slots got=%b want=0000", slot_valid); end
      do_write(2'd0, 16'h0005);
      do_write(2'd2, 16'hFFFD);
      do_write(2'd3, 16'h0002);
      tick(4);
      total++; if (disp_addr !== 2'd0 || disp_data !== 16'h0005) begin bad++; $display("FAIL step_start got=%0d/%h want=0/0005", disp_addr, disp_data); end
      prev_a = 2'd0;
      for (int i = 0; i < 3; i++) begin
         pulse_step;
         tick(2);
         total++; if (disp_addr !== prev_a) begin bad++; $display("FAIL step_latency_%0d got=%0d want=%0d", i, disp_addr, prev_a); end
         tick(1);
         total++; if (disp_addr !== exp_a[i]) begin bad++; $display("FAIL step_addr_%0d got=%0d want=%0d", i, disp_addr, exp_a[i]); end
         total++; if (disp_data !== exp_d[i]) begin bad++; $display("FAIL step_data_%0d got=%h want=%h", i, disp_data, exp_d[i]); end
         prev_a = exp_a[i];
         tick(2);
      end
      tick(20);
      total++; if (disp_addr !== 2'd0) begin bad++; $display("FAIL step_frozen got=%0d want=0", disp_addr); end
   endtask

   task automatic test_auto;
      logic [1:0]  prev_a;
      logic [1:0]  exp_a [2] = '{2'd0, 2'd1};
      logic [15:0] exp_d [2] = '{16'h0011, 16'h0022};
      int n;
      pulse_clr;
      do_write(2'd0, 16'h0011);
      do_write(2'd1, 16'h0022);
      tick(4);
      total++; if (disp_addr !== 2'd0 || disp_valid !== 1'b1) begin bad++; $display("FAIL auto_start got=%0d/%0b want=0/1", disp_addr, disp_valid); end
      auto_en = 1'b1;
      n = 0;
      while (disp_addr === 2'd0 && n < 40) begin tick(1); n++; end
      total++; if (disp_addr !== 2'd1) begin bad++; $display("FAIL auto_first_switch got=%0d want=1", disp_addr); end
      for (int r = 0; r < 2; r++) begin
         prev_a = disp_addr;
         n = 0;
         while (disp_addr === prev_a && n < 40) begin tick(1); n++; end
         total++; if (n !== 11) begin bad++; $display("FAIL auto_period_%0d got=%0d want=11", r, n); end
         total++; if (disp_addr !== exp_a[r]) begin bad++; $display("FAIL auto_addr_%0d got=%0d want=%0d", r, disp_addr, exp_a[r]); end
         total++; if (disp_data !== exp_d[r]) begin bad++; $display("FAIL auto_data_%0d got=%h want=%h", r, disp_data, exp_d[r]); end
      end
      auto_en = 1'b0;
      tick(30);
      total++; if (disp_addr !== 2'd1) begin bad++; $display("FAIL auto_freeze got=%0d want=1", disp_addr); end
   endtask

   task automatic test_refresh;
      pulse_clr;
      do_write(2'd2, 16'h0010);
      tick(4);
      total++; if (disp_addr !== 2'd2 || disp_data !== 16'h0010) begin bad++; $display("FAIL refresh_start got=%0d/%h want=2/0010", disp_addr, disp_data); end
      do_write(2'd2, 16'h0020);
      tick(1);
      total++; if (disp_data !== 16'h0010) begin bad++; $display("FAIL refresh_early got=%h want=0010", disp_data); end
      tick(1);
      total++; if (disp_data !== 16'h0020) begin bad++; $display("FAIL refresh_data got=%h want=0020", disp_data); end
      total++; if (disp_addr !== 2'd2) begin bad++; $display("FAIL refresh_addr got=%0d want=2", disp_addr); end
   endtask

   task automatic test_clr;
      pulse_step;
      tick(1);
      pulse_clr;
      total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL clr_disp_valid got=%0b want=0", disp_valid); end
      total++; if (slot_valid !== 4'b0000) begin bad++; $display("FAIL clr_slot_valid got=%b want=0000", slot_valid); end
      total++; if (disp_data !== 16'h0020 || disp_addr !== 2'd2) begin bad++; $display("FAIL clr_hold got=%0d/%h want=2/0020", disp_addr, disp_data); end
      tick(5);
      total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL clr_stays_idle got=%0b want=0", disp_valid); end
      clr = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h0099;
      tick(1);
      clr = 1'b0; wr_en = 1'b0;
      total++; if (slot_valid !== 4'b0000) begin bad++; $display("FAIL clr_wins_slot got=%b want=0000", slot_valid); end
      tick(5);
      total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL clr_wins_idle got=%0b want=0", disp_valid); end
   endtask

   task automatic test_reset_mid;
      do_write(2'd0, 16'h0ABC);
      tick(3);
      rst_n = 1'b0;
      #2;
      total++; if (disp_valid !== 1'b0 || slot_valid !== 4'b0000) begin bad++; $display("FAIL rstmid_flags got=%0b/%b want=0/0000", disp_valid, slot_valid); end
      total++; if (disp_data !== 16'h0000 || disp_addr !== 2'd0 || rd_addr !== 2'd0) begin bad++; $display("FAIL rstmid_regs got=%h/%0d/%0d want=0000/0/0", disp_data, disp_addr, rd_addr); end
      tick(2);
      total++; if (disp_valid !== 1'b0 || slot_valid !== 4'b0000) begin bad++; $display("FAIL rstmid_held got=%0b/%b want=0/0000", disp_valid, slot_valid); end
      rst_n = 1'b1;
      tick(3);
      do_write(2'd3, 16'h0333);
      tick(4);
      total++; if (disp_valid !== 1'b1 || disp_addr !== 2'd3) begin bad++; $display("FAIL rstmid_first got=%0b/%0d want=1/3", disp_valid, disp_addr); end
      total++; if (disp_data !== 16'h0333) begin bad++; $display("FAIL rstmid_data got=%h want=0333", disp_data); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_first_write;
      test_step;
      test_auto;
      test_refresh;
      test_clr;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
